// File: rtl/hdmi_video_timing_ctrl_if.sv
// Video-side bundle between the timing controller and the
// pixel source / TMDS encoder stage.
interface hdmi_video_timing_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             de;
    logic             hsync;
    logic             vsync;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             pix_valid;
    logic             pix_ready;
    logic             frame_start;
    logic             line_start;
    logic [1:0]       tmds_ctrl_b;

    modport master (
        output de, hsync, vsync, x, y,
        output pix_ready, frame_start,
        output line_start, tmds_ctrl_b,
        input  pix_valid
    );

    modport slave (
        input  de, hsync, vsync, x, y,
        input  pix_ready, frame_start,
        input  line_start, tmds_ctrl_b,
        output pix_valid
    );
endinterface

// File: rtl/hdmi_video_timing_ctrl.sv
// Raster timing generator for the HDMI/DVI path; starts and
// stops on frame boundaries and flags pixel underflow.
module hdmi_video_timing_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clr_underflow,
    output logic busy,
    output logic underflow,
    hdmi_video_timing_ctrl_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC - 1;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] h, v;
    logic             h_last, v_last, frame_last;
    logic             active, hs_act, vs_act;
    logic             hs_q, vs_q;

    always_comb begin
        h_last     = (h == CNT_W'(H_TOTAL - 1));
        v_last     = (v == CNT_W'(V_TOTAL - 1));
        frame_last = h_last && v_last;
        active     = (h < CNT_W'(H_ACTIVE)) &&
                     (v < CNT_W'(V_ACTIVE));
        hs_act     = (h >= CNT_W'(HS_BEG)) &&
                     (h <= CNT_W'(HS_END));
        vs_act     = (v >= CNT_W'(VS_BEG)) &&
                     (v <= CNT_W'(VS_END));
    end

    // Stopping is only honoured on the last pixel of a frame.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (enable) state_n = RUN;
            RUN, DRAIN: begin
                if (frame_last && !enable)
                    state_n = IDLE;
                else if (enable)
                    state_n = RUN;
                else
                    state_n = DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Outputs show the counter position of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            vid.de          <= 1'b0;
            vid.pix_ready   <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.frame_start <= 1'b0;
            vid.line_start  <= 1'b0;
            hs_q            <= ~HSYNC_POL;
            vs_q            <= ~VSYNC_POL;
            busy            <= 1'b0;
        end else begin
            vid.de          <= active;
            vid.pix_ready   <= active;
            vid.x           <= active ? h : '0;
            vid.y           <= active ? v : '0;
            vid.frame_start <= (h == '0) && (v == '0);
            vid.line_start  <= (h == '0) &&
                               (v < CNT_W'(V_ACTIVE));
            hs_q            <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vs_q            <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            busy            <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            underflow <= 1'b0;
        else if (vid.de && !vid.pix_valid)
            underflow <= 1'b1;
        else if (clr_underflow)
            underflow <= 1'b0;
    end

    assign vid.hsync       = hs_q;
    assign vid.vsync       = vs_q;
    assign vid.tmds_ctrl_b = {vs_q, hs_q};
endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Directed bench for hdmi_video_timing_ctrl on an 8x6
// raster; expected outputs derived from the frame position.
module tb_hdmi_video_timing_ctrl;
    localparam int CNT_W = 11;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic clr_underflow;
    logic busy;
    logic underflow;

    int n_vec  = 0;
    int n_miss = 0;
    int cur_n  = 0;

    hdmi_video_timing_ctrl_if #(.CNT_W(CNT_W)) vif ();

    hdmi_video_timing_ctrl #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clr_underflow(clr_underflow),
        .busy         (busy),
        .underflow    (underflow),
        .vid          (vif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s n=%0d got=%0h exp=%0h",
                     tag, cur_n, got, exp);
        end
    endtask

    // n<0: idle outputs expected; else n cycles into the run.
    task automatic step(input int n, input logic uf);
        int  p, h, v;
        logic act, hs, vs;
        @(negedge clk);
        cur_n = n;
        if (n < 0) begin
            chk("de", 32'(vif.de), 0);
            chk("rdy", 32'(vif.pix_ready), 0);
            chk("x", 32'(vif.x), 0);
            chk("y", 32'(vif.y), 0);
            chk("hs", 32'(vif.hsync), 1);
            chk("vs", 32'(vif.vsync), 1);
            chk("fs", 32'(vif.frame_start), 0);
            chk("ls", 32'(vif.line_start), 0);
            chk("ctl", 32'(vif.tmds_ctrl_b), 3);
            chk("busy", 32'(busy), 0);
        end else begin
            p   = n % 48;
            h   = p % 8;
            v   = p / 8;
            act = (h < 4) && (v < 3);
            hs  = !(h == 5 || h == 6);
            vs  = (v != 4);
            chk("de", 32'(vif.de), 32'(act));
            chk("rdy", 32'(vif.pix_ready), 32'(act));
            chk("x", 32'(vif.x), act ? h : 0);
            chk("y", 32'(vif.y), act ? v : 0);
            chk("hs", 32'(vif.hsync), 32'(hs));
            chk("vs", 32'(vif.vsync), 32'(vs));
            chk("fs", 32'(vif.frame_start), 32'(p == 0));
            chk("ls", 32'(vif.line_start),
                32'(h == 0 && v < 3));
            chk("ctl", 32'(vif.tmds_ctrl_b),
                32'({vs, hs}));
            chk("busy", 32'(busy), 1);
        end
        chk("uf", 32'(underflow), 32'(uf));
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        clr_underflow = 1'b0;
        vif.pix_valid = 1'b1;
        repeat (2) @(posedge clk);
        step(-1, 1'b0);
        rst = 1'b0;
        step(-1, 1'b0);
        enable = 1'b1;
        step(-1, 1'b0);

        // run 1: underflow set/clear, stop mid frame 2
        for (int n = 0; n < 96; n++) begin
            step(n, (n >= 2 && n <= 20));
            vif.pix_valid = !(n == 1 || n == 10);
            clr_underflow = (n == 10 || n == 20);
            if (n == 58) enable = 1'b0;
        end
        for (int i = 0; i < 10; i++)
            step(-1, 1'b0);

        // run 2: drop and re-raise inside a frame, then rst
        enable = 1'b1;
        step(-1, 1'b0);
        for (int n = 0; n <= 58; n++) begin
            step(n, (n >= 50));
            vif.pix_valid = (n != 49);
            if (n == 10) enable = 1'b0;
            if (n == 30) enable = 1'b1;
        end
        rst = 1'b1;
        step(-1, 1'b0);
        rst = 1'b0;
        step(-1, 1'b0);
        for (int n = 0; n < 12; n++)
            step(n, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end
endmodule
